// File: rtl/byte_fifo_axi_writer.sv
// Byte FIFO to AXI4-Lite writer.
// Packs bytes little-endian into words and issues one AXI4-Lite write per word
// into a wrapping address window. A flush pushes out a partial word.
module byte_fifo_axi_writer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    WRAP_BYTES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                fifo_data,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    input  logic                      flush,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic                      busy,
    output logic                      err,
    output logic [31:0]               word_count
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(BPW + 1);

    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(BPW);
    localparam logic [ADDR_WIDTH-1:0] WRAP_END = BASE_ADDR + ADDR_WIDTH'(WRAP_BYTES);

    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] SEND   = 2'd1;
    localparam logic [1:0] WAIT_B = 2'd2;

    logic [1:0]            state_q,      state_d;
    logic [CNT_W-1:0]      byte_cnt_q,   byte_cnt_d;
    logic                  pend_q,       pend_d;
    logic                  flush_req_q,  flush_req_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic [BPW-1:0]        wstrb_q,      wstrb_d;
    logic                  awvalid_q,    awvalid_d;
    logic                  wvalid_q,     wvalid_d;
    logic                  err_q,        err_d;
    logic [31:0]           word_cnt_q,   word_cnt_d;

    // Next word address; a partial write still consumes a full word slot.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] n;
        n = a + STEP;
        if (n == WRAP_END) n = BASE_ADDR;
        return n;
    endfunction

    logic [CNT_W:0] fill_level;
    assign fill_level = {1'b0, byte_cnt_q} + (CNT_W + 1)'(pend_q);

    // Read only in FILL, never past a full word counting the in-flight byte,
    // and stop issuing reads once a flush is waiting with nothing in flight.
    assign fifo_rd_en = rst && (state_q == FILL) && !fifo_empty
                        && (fill_level < (CNT_W + 1)'(BPW))
                        && !(flush_req_q && !pend_q);

    assign m_awaddr   = addr_q;
    assign m_awvalid  = awvalid_q;
    assign m_wdata    = wdata_q;
    assign m_wstrb    = wstrb_q;
    assign m_wvalid   = wvalid_q;
    assign m_bready   = (state_q == WAIT_B);
    assign busy       = (state_q != FILL) || (byte_cnt_q != '0);
    assign err        = err_q;
    assign word_count = word_cnt_q;

    // Next-state logic: byte packing, AW/W handshakes and B-response bookkeeping.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        pend_d      = fifo_rd_en && !fifo_empty;
        flush_req_d = flush_req_q || flush;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        err_d       = err_q;
        word_cnt_d  = word_cnt_q;
        case (state_q)
            FILL: begin
                if (pend_q) begin
                    for (int i = 0; i < BPW; i++) begin
                        if (byte_cnt_q == CNT_W'(i)) begin
                            wdata_d[i*8 +: 8] = fifo_data;
                            wstrb_d[i]        = 1'b1;
                        end
                    end
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q == CNT_W'(BPW - 1)) begin
                        state_d     = SEND;
                        awvalid_d   = 1'b1;
                        wvalid_d    = 1'b1;
                        flush_req_d = 1'b0;
                    end
                end else if (flush_req_q) begin
                    // An empty pack register means the flush has nothing to send.
                    if (byte_cnt_q != '0) begin
                        state_d   = SEND;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                    flush_req_d = 1'b0;
                end
            end
            SEND: begin
                awvalid_d = awvalid_q && !m_awready;
                wvalid_d  = wvalid_q && !m_wready;
                if (!awvalid_d && !wvalid_d) state_d = WAIT_B;
            end
            WAIT_B: begin
                if (m_bvalid) begin
                    err_d      = err_q || (m_bresp != 2'b00);
                    word_cnt_d = word_cnt_q + 32'd1;
                    byte_cnt_d = '0;
                    wstrb_d    = '0;
                    wdata_d    = '0;
                    addr_d     = next_addr(addr_q);
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State registers; reset abandons any transaction in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FILL;
            byte_cnt_q  <= '0;
            pend_q      <= 1'b0;
            flush_req_q <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            pend_q      <= pend_d;
            flush_req_q <= flush_req_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            err_q       <= err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_byte_fifo_axi_writer.sv
// Directed testbench for byte_fifo_axi_writer (4-byte words, 16-byte window at 0x1000).
module tb_byte_fifo_axi_writer;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        flush;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic        busy;
    logic        err;
    logic [31:0] word_count;

    byte_fifo_axi_writer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .WRAP_BYTES(16)
    ) dut (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_awaddr(m_awaddr),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy(busy), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after a read of a non-empty FIFO.
    logic [7:0] mem [256];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    // Handshake monitor logs each accepted address and data beat.
    logic [31:0] aw_log   [64];
    logic [31:0] data_log [64];
    logic [3:0]  strb_log [64];
    int aw_n = 0;
    int w_n  = 0;

    always @(posedge clk) begin
        if (m_awvalid && m_awready) begin
            aw_log[aw_n] <= m_awaddr;
            aw_n         <= aw_n + 1;
        end
        if (m_wvalid && m_wready) begin
            data_log[w_n] <= m_wdata;
            strb_log[w_n] <= m_wstrb;
            w_n           <= w_n + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_wc(input int n, input string tag);
        int k;
        k = 0;
        while (word_count != 32'(n) && k < 200) begin
            tick();
            k++;
        end
        check(tag, word_count, n);
    endtask

    task automatic wait_aw(input string tag);
        int k;
        k = 0;
        while (!m_awvalid && k < 200) begin
            tick();
            k++;
        end
        check(tag, m_awvalid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ab;
        rst = 1'b0; flush = 1'b0; wr_ptr = 8'd0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;

        // Reset state
        tick(); tick();
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_bready", m_bready, 0);
        check("rst_addr", m_awaddr, BASE);
        check("rst_wcount", word_count, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;

        // Two full words back to back
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
        ab = aw_n;
        for (int i = 0; i < 8; i++) push(8'((i + 1) * 17));
        wait_wc(2, "full_wc");
        check("full_addr0", aw_log[ab], BASE);
        check("full_addr1", aw_log[ab+1], BASE + 32'h4);
        check("full_data0", data_log[ab], 32'h4433_2211);
        check("full_data1", data_log[ab+1], 32'h8877_6655);
        check("full_strb0", strb_log[ab], 4'hF);
        check("full_strb1", strb_log[ab+1], 4'hF);
        check("full_nextaddr", m_awaddr, BASE + 32'h8);
        check("full_idle", busy, 0);

        // Partial word pushed out by flush, then a full word
        do_reset();
        ab = aw_n;
        push(8'hAA); push(8'hBB);
        tick(); tick(); tick(); tick();
        check("part_busy", busy, 1);
        check("part_nowrite", m_awvalid, 0);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_wc(1, "part_wc");
        check("part_addr", aw_log[ab], BASE);
        check("part_data", data_log[ab], 32'h0000_BBAA);
        check("part_strb", strb_log[ab], 4'b0011);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_wc(2, "after_part_wc");
        check("after_part_addr", aw_log[ab+1], BASE + 32'h4);
        check("after_part_data", data_log[ab+1], 32'h0403_0201);
        check("after_part_strb", strb_log[ab+1], 4'hF);
        // Flush with nothing buffered issues no write
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("empty_flush_wc", word_count, 2);
        check("empty_flush_aw", aw_n, ab + 2);
        check("empty_flush_busy", busy, 0);

        // Address channel stalled while data channel is ready
        do_reset();
        m_awready = 1'b0; m_wready = 1'b1; m_bvalid = 1'b0;
        push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
        tick(); tick(); tick(); tick();
        check("lat_not_yet", m_awvalid, 0);
        tick();
        check("lat_awvalid", m_awvalid, 1);
        check("lat_wvalid", m_wvalid, 1);
        check("stall_addr0", m_awaddr, BASE);
        check("stall_wdata", m_wdata, 32'hD3D2_D1D0);
        check("stall_wstrb", m_wstrb, 4'hF);
        tick();
        check("stall_wdrop", m_wvalid, 0);
        check("stall_awhold1", m_awvalid, 1);
        tick();
        check("stall_awhold2", m_awvalid, 1);
        check("stall_addr2", m_awaddr, BASE);
        check("stall_nobready", m_bready, 0);
        m_awready = 1'b1;
        tick();
        check("stall_awdone", m_awvalid, 0);
        check("stall_bready", m_bready, 1);
        check("stall_wc0", word_count, 0);
        m_bvalid = 1'b1;
        tick();
        check("stall_wc1", word_count, 1);
        check("stall_bdone", m_bready, 0);
        check("stall_err", err, 0);

        // Address wrap inside the 16-byte window
        do_reset();
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
        ab = aw_n;
        for (int i = 0; i < 20; i++) push(8'(i));
        wait_wc(5, "wrap_wc");
        check("wrap_a0", aw_log[ab],   BASE);
        check("wrap_a1", aw_log[ab+1], BASE + 32'h4);
        check("wrap_a2", aw_log[ab+2], BASE + 32'h8);
        check("wrap_a3", aw_log[ab+3], BASE + 32'hC);
        check("wrap_a4", aw_log[ab+4], BASE);
        check("wrap_d4", data_log[ab+4], 32'h1312_1110);
        check("wrap_next", m_awaddr, BASE + 32'h4);

        // Sticky error on SLVERR
        do_reset();
        m_bresp = 2'b00;
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        wait_wc(1, "err_wc1");
        check("err_clear", err, 0);
        m_bresp = 2'b10;
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
        wait_wc(2, "err_wc2");
        check("err_set", err, 1);
        m_bresp = 2'b00;
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
        wait_wc(3, "err_wc3");
        check("err_sticky", err, 1);

        // Reset while a write is outstanding
        m_awready = 1'b0; m_wready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
        wait_aw("rstmid_send");
        push(8'h60); push(8'h61);
        rst = 1'b0;
        tick();
        check("rstmid_awvalid", m_awvalid, 0);
        check("rstmid_wvalid", m_wvalid, 0);
        check("rstmid_bready", m_bready, 0);
        check("rstmid_addr", m_awaddr, BASE);
        check("rstmid_wc", word_count, 0);
        check("rstmid_err", err, 0);
        check("rstmid_rden", fifo_rd_en, 0);
        tick();
        check("rstmid_rden2", fifo_rd_en, 0);
        check("rstmid_busy", busy, 0);
        rst = 1'b1;
        tick();
        check("rstrel_rden", fifo_rd_en, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/byte_fifo_axi_writer.md
Name: byte_fifo_axi_writer

Overview:
- Drains the byte stream held in the UART-side byte FIFO and packs the bytes little-endian into DATA_WIDTH-bit words.
- Issues each word as a single AXI4-Lite write toward the DDR controller.
- The write address starts at BASE_ADDR, increments by one word per write, and wraps inside a WRAP_BYTES window.
- A flush request forces out a partial word, with strobes covering only the filled bytes.

Parameters:
DATA_WIDTH, 32, AXI write data width; multiple of 8, at least 16; BPW = DATA_WIDTH/8
ADDR_WIDTH, 32, AXI address width
BASE_ADDR, 32'h0000_0000, first write address; BPW-aligned
WRAP_BYTES, 4096, address window size in bytes; multiple of BPW

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
fifo_data  in  8  FIFO read data; valid the cycle after fifo_rd_en && !fifo_empty
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO read enable (combinational)
flush  in  1  pulse: push out the partial word
m_awaddr  out  ADDR_WIDTH  write address
m_awvalid  out  1  address valid
m_awready  in  1  address ready
m_wdata  out  DATA_WIDTH  write data
m_wstrb  out  BPW  byte strobes
m_wvalid  out  1  data valid
m_wready  in  1  data ready
m_bresp  in  2  write response
m_bvalid  in  1  response valid
m_bready  out  1  response ready
busy  out  1  high in any state other than FILL, or while byte_cnt != 0
err  out  1  sticky; set on any bresp != 2'b00
word_count  out  32  completed writes; wraps at 2^32

Behaviour:
- Reset (rst==0 at posedge): state=FILL, byte_cnt=0, pend=0, flush_req=0, addr=BASE_ADDR, wdata/wstrb=0, err=0, word_count=0.
  - All valid and ready outputs are 0. Reset mid-transaction abandons it immediately; no AXI signal is held.
- FIFO side:
  - fifo_rd_en = (state==FILL) && !fifo_empty && (byte_cnt + pend < BPW) && !(flush_req && !pend).
  - pend is a registered copy of fifo_rd_en && !fifo_empty, so one read may be in flight.
  - The byte is accepted when pend==1: lane byte_cnt of the pack register gets fifo_data, strobe bit byte_cnt is set, and byte_cnt increments.
  - First byte goes to [7:0].
  - Back-to-back reads give one byte per cycle.
- FILL -> SEND:
  - Trigger (a): byte_cnt reaches BPW, i.e. the accept cycle where byte_cnt==BPW-1. m_wstrb is all-ones.
  - Trigger (b): flush_req==1, pend==0 and byte_cnt>0. m_wstrb has only the filled lanes set; unfilled lanes of m_wdata are 0.
  - flush_req is cleared on either transition.
  - flush_req==1 with byte_cnt==0 and pend==0 clears flush_req and issues no write.
- SEND:
  - m_awvalid and m_wvalid rise together on entry.
  - Each drops independently after its own valid&&ready handshake.
  - addr, wdata and wstrb are stable throughout SEND.
  - When both handshakes are done (same cycle or different cycles), go to WAIT_B.
- WAIT_B:
  - m_bready=1. On m_bvalid: err |= (m_bresp!=0), word_count++, byte_cnt=0, strobes cleared.
  - addr advances by BPW; if addr+BPW == BASE_ADDR+WRAP_BYTES, addr returns to BASE_ADDR. A partial write also advances a full word.
  - Next state is FILL.
- Flush arriving in SEND or WAIT_B is latched in flush_req and serviced in FILL.
- flush coinciding with a byte accept includes that byte.
- No FIFO reads occur outside FILL. The FIFO may fill; this block never drops bytes.
- Latency: the word's AW/W valid rises 1 cycle after the accept of its last byte.

Test Plan:
- Push 8 bytes 0x11..0x88, ready/bvalid=1 -> two writes: addr 0x0 data 0x44332211, addr 0x4 data 0x88776655, strb 4'hF each, word_count=2.
- Push 0xAA,0xBB, then flush -> one write: data 0x0000BBAA, strb 4'b0011, addr 0x0; next full word lands at 0x4.
- awready held 0 for 3 cycles while wready=1 -> wvalid drops after 1 cycle, awvalid held with stable addr until its handshake, then one B accepted.
- WRAP_BYTES=16, push 20 bytes -> addresses 0x0,0x4,0x8,0xC,0x0.
- bresp=2'b10 on the second write -> err=1 from then on, word_count still increments; a later OKAY leaves err=1.
- Assert rst during SEND -> next cycle awvalid=wvalid=bready=0, addr=BASE_ADDR, word_count=0, fifo_rd_en=0 while rst low.
